// File: rtl/barvinn_pkg.sv
// Shared constants and types for the MVU completion/interrupt controller.
package barvinn_pkg;

    localparam int N_MVU_DEF       = 8;
    localparam int TIMEOUT_CYC_DEF = 65535;
    localparam int CNT_W_DEF       = 16;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'b00,
        IRQ_BUSY = 2'b01,
        IRQ_TMO  = 2'b10
    } irq_slot_state_e;

    // Job timer width; at least one bit so a disabled timeout still elaborates.
    function automatic int timer_width(input int tmo_cyc);
        if (tmo_cyc < 1) begin
            return 1;
        end else begin
            return $clog2(tmo_cyc + 1);
        end
    endfunction

endpackage

// File: rtl/mvu_irq_slot.sv
// One MVU job tracker: IDLE/BUSY/TMO state, job timer, pending interrupt bit
// and saturating completion counter.
module mvu_irq_slot
    import barvinn_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             done_i,
    input  logic             ack_i,
    output logic             pending_o,
    output logic             busy_o,
    output logic             timeout_err_o,
    output logic [CNT_W-1:0] done_cnt_o
);

    localparam int               CNT_T    = timer_width(TIMEOUT_CYC);
    localparam bit               TMO_EN   = (TIMEOUT_CYC > 0);
    localparam logic [CNT_T-1:0] TMO_LAST = CNT_T'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    irq_slot_state_e  state_q, state_d;
    logic [CNT_T-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             pend_set_s;
    logic             cnt_inc_s;

    // Next-state, timer, flag and counter logic.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        err_d      = err_q;
        pend_set_s = 1'b0;
        cnt_inc_s  = 1'b0;
        case (state_q)
            IRQ_IDLE: begin
                if (start_i) begin
                    state_d = IRQ_BUSY;
                    timer_d = '0;
                end else begin
                    state_d = IRQ_IDLE;
                end
            end
            IRQ_BUSY: begin
                // A done arriving on the timeout cycle still counts as success.
                if (done_i) begin
                    state_d    = IRQ_IDLE;
                    pend_set_s = 1'b1;
                    cnt_inc_s  = 1'b1;
                end else if (TMO_EN && (timer_q == TMO_LAST)) begin
                    state_d    = IRQ_TMO;
                    err_d      = 1'b1;
                    pend_set_s = 1'b1;
                end else if (TMO_EN) begin
                    timer_d = timer_q + CNT_T'(1'b1);
                end else begin
                    timer_d = timer_q;
                end
            end
            IRQ_TMO: begin
                cnt_inc_s = done_i;
                if (ack_i) begin
                    state_d = IRQ_IDLE;
                    err_d   = 1'b0;
                end else begin
                    state_d = IRQ_TMO;
                end
            end
            default: begin
                state_d = IRQ_IDLE;
                timer_d = '0;
                err_d   = 1'b0;
            end
        endcase

        if (pend_set_s) begin
            pending_d = 1'b1;
        end else if (ack_i) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end

        if (cnt_inc_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end

        busy_d = (state_d == IRQ_BUSY);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IRQ_IDLE;
            timer_q   <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign pending_o     = pending_q;
    assign busy_o        = busy_q;
    assign timeout_err_o = err_q;
    assign done_cnt_o    = cnt_q;

endmodule

// File: rtl/mvu_irq_ctrl.sv
// Completion/interrupt controller between the MVU array and the pito harts:
// one job tracker per MVU, level interrupt per hart, flat counter packing.
module mvu_irq_ctrl
    import barvinn_pkg::*;
#(
    parameter int N_MVU       = N_MVU_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_MVU-1:0]       mvu_start_i,
    input  logic [N_MVU-1:0]       mvu_done_i,
    input  logic [N_MVU-1:0]       irq_en_i,
    input  logic [N_MVU-1:0]       irq_ack_i,
    output logic [N_MVU-1:0]       mvu_irq_o,
    output logic [N_MVU-1:0]       mvu_busy_o,
    output logic [N_MVU-1:0]       timeout_err_o,
    output logic [N_MVU*CNT_W-1:0] done_cnt_o
);

    logic [N_MVU-1:0] pending_s;

    for (genvar g = 0; g < N_MVU; g++) begin : g_slot
        mvu_irq_slot #(
            .TIMEOUT_CYC (TIMEOUT_CYC),
            .CNT_W       (CNT_W)
        ) u_slot (
            .clk           (clk),
            .rst_n         (rst_n),
            .start_i       (mvu_start_i[g]),
            .done_i        (mvu_done_i[g]),
            .ack_i         (irq_ack_i[g]),
            .pending_o     (pending_s[g]),
            .busy_o        (mvu_busy_o[g]),
            .timeout_err_o (timeout_err_o[g]),
            .done_cnt_o    (done_cnt_o[g*CNT_W +: CNT_W])
        );
    end

    // Masking gates the request only; the pending bit survives in the slot.
    assign mvu_irq_o = pending_s & irq_en_i;

endmodule

// File: tb/tb_mvu_irq_ctrl.sv
// Directed self-checking bench for mvu_irq_ctrl (TIMEOUT_CYC=100; a second
// instance with CNT_W=4 exercises counter saturation).
module tb_mvu_irq_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  start_a, done_a, en_a, ack_a;
    logic [7:0]  irq_a, busy_a, err_a;
    logic [127:0] cnt_a;
    logic [7:0]  start_b, done_b, en_b, ack_b;
    logic [7:0]  irq_b, busy_b, err_b;
    logic [31:0] cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    mvu_irq_ctrl #(.N_MVU(8), .TIMEOUT_CYC(100), .CNT_W(16)) u_dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .mvu_start_i   (start_a),
        .mvu_done_i    (done_a),
        .irq_en_i      (en_a),
        .irq_ack_i     (ack_a),
        .mvu_irq_o     (irq_a),
        .mvu_busy_o    (busy_a),
        .timeout_err_o (err_a),
        .done_cnt_o    (cnt_a)
    );

    mvu_irq_ctrl #(.N_MVU(8), .TIMEOUT_CYC(100), .CNT_W(4)) u_dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .mvu_start_i   (start_b),
        .mvu_done_i    (done_b),
        .irq_en_i      (en_b),
        .irq_ack_i     (ack_b),
        .mvu_irq_o     (irq_b),
        .mvu_busy_o    (busy_b),
        .timeout_err_o (err_b),
        .done_cnt_o    (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] cnt_of(input int i);
        return cnt_a[i*16 +: 16];
    endfunction

    initial begin
        rst_n   = 1'b0;
        start_a = 8'h00; done_a = 8'h00; en_a = 8'hFF; ack_a = 8'h00;
        start_b = 8'h00; done_b = 8'h00; en_b = 8'hFF; ack_b = 8'h00;
        step();
        step();
        chk("rst_irq",  {24'd0, irq_a},  32'h0);
        chk("rst_busy", {24'd0, busy_a}, 32'h0);
        chk("rst_err",  {24'd0, err_a},  32'h0);
        chk("rst_cnt",  cnt_a[31:0] | cnt_a[127:96], 32'h0);
        rst_n = 1'b1;
        step();

        // 1: start[0] at cycle 0, done[0] at cycle 20
        start_a = 8'h01; step(); start_a = 8'h00;
        chk("t1_busy_rise", {24'd0, busy_a}, 32'h01);
        repeat (19) step();
        chk("t1_busy_c19", {24'd0, busy_a}, 32'h01);
        chk("t1_irq_c19",  {24'd0, irq_a},  32'h00);
        done_a = 8'h01; step(); done_a = 8'h00;
        chk("t1_busy_fall", {24'd0, busy_a}, 32'h00);
        chk("t1_irq",       {24'd0, irq_a},  32'h01);
        chk("t1_cnt0",      {16'd0, cnt_of(0)}, 32'd1);
        ack_a = 8'h01; step(); ack_a = 8'h00;
        chk("t1_irq_ack", {24'd0, irq_a}, 32'h00);

        // 2: start[3] with no done -> timeout after 100 cycles in BUSY
        start_a = 8'h08; step(); start_a = 8'h00;
        repeat (99) step();
        chk("t2_err_pre",  {24'd0, err_a},  32'h00);
        chk("t2_busy_pre", {24'd0, busy_a}, 32'h08);
        step();
        chk("t2_err",  {24'd0, err_a},  32'h08);
        chk("t2_irq",  {24'd0, irq_a},  32'h08);
        chk("t2_busy", {24'd0, busy_a}, 32'h00);
        done_a = 8'h08; step(); done_a = 8'h00;
        chk("t2_late_cnt", {16'd0, cnt_of(3)}, 32'd1);
        chk("t2_late_err", {24'd0, err_a}, 32'h08);
        start_a = 8'h08; step(); start_a = 8'h00;
        chk("t2_tmo_start_ignored", {24'd0, busy_a}, 32'h00);
        ack_a = 8'h08; step(); ack_a = 8'h00;
        chk("t2_ack_err", {24'd0, err_a}, 32'h00);
        chk("t2_ack_irq", {24'd0, irq_a}, 32'h00);
        start_a = 8'h08; step(); start_a = 8'h00;
        chk("t2_idle_restart", {24'd0, busy_a}, 32'h08);
        // start together with done in BUSY: done taken, start dropped
        start_a = 8'h08; done_a = 8'h08; step(); start_a = 8'h00; done_a = 8'h00;
        chk("t2_sd_busy", {24'd0, busy_a}, 32'h00);
        chk("t2_sd_cnt",  {16'd0, cnt_of(3)}, 32'd2);
        step();
        chk("t2_sd_stay_idle", {24'd0, busy_a}, 32'h00);
        ack_a = 8'h08; step(); ack_a = 8'h00;

        // 3: done+ack same cycle keeps pending; spurious done in IDLE
        start_a = 8'h20; step(); start_a = 8'h00;
        done_a  = 8'h20; step(); done_a  = 8'h00;
        chk("t3_irq_set", {24'd0, irq_a}, 32'h20);
        start_a = 8'h20; step(); start_a = 8'h00;
        chk("t3_start_pend_busy", {24'd0, busy_a}, 32'h20);
        chk("t3_start_pend_irq",  {24'd0, irq_a},  32'h20);
        done_a = 8'h20; ack_a = 8'h20; step(); done_a = 8'h00; ack_a = 8'h00;
        chk("t3_set_wins", {24'd0, irq_a}, 32'h20);
        chk("t3_cnt5",     {16'd0, cnt_of(5)}, 32'd2);
        ack_a = 8'h20; step(); ack_a = 8'h00;
        chk("t3_ack_clear", {24'd0, irq_a}, 32'h00);
        done_a = 8'h04; step(); done_a = 8'h00;
        chk("t3_spur_cnt2", {16'd0, cnt_of(2)}, 32'd0);
        chk("t3_spur_irq",  {24'd0, irq_a}, 32'h00);

        // 4: masked completions, then unmask the same cycle
        en_a = 8'h00;
        start_a = 8'hFF; step(); start_a = 8'h00;
        chk("t4_busy_all", {24'd0, busy_a}, 32'hFF);
        done_a  = 8'hFF; step(); done_a  = 8'h00;
        chk("t4_masked", {24'd0, irq_a}, 32'h00);
        step();
        en_a = 8'hFF; #1;
        chk("t4_unmask", {24'd0, irq_a}, 32'hFF);
        chk("t4_cnt7",   {16'd0, cnt_of(7)}, 32'd1);
        ack_a = 8'hFF; step(); ack_a = 8'h00;
        chk("t4_ack_all", {24'd0, irq_a}, 32'h00);

        // timeout and done on the same cycle: done wins
        start_a = 8'h10; step(); start_a = 8'h00;
        repeat (99) step();
        done_a = 8'h10; step(); done_a = 8'h00;
        chk("tx_tmo_done_err", {24'd0, err_a}, 32'h00);
        chk("tx_tmo_done_cnt", {16'd0, cnt_of(4)}, 32'd2);
        chk("tx_tmo_done_irq", {24'd0, irq_a}, 32'h10);
        ack_a = 8'h10; step(); ack_a = 8'h00;

        // 6: reset mid-job on MVU 6 clears everything immediately
        start_a = 8'h40; step(); start_a = 8'h00;
        repeat (5) step();
        chk("t6_busy_pre", {24'd0, busy_a}, 32'h40);
        rst_n = 1'b0; #1;
        chk("t6_rst_busy", {24'd0, busy_a}, 32'h00);
        chk("t6_rst_irq",  {24'd0, irq_a},  32'h00);
        chk("t6_rst_err",  {24'd0, err_a},  32'h00);
        chk("t6_rst_cnt",  {16'd0, cnt_of(6)}, 32'd0);
        chk("t6_rst_cnt0", {16'd0, cnt_of(0)}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        start_a = 8'h40; step(); start_a = 8'h00;
        chk("t6_new_busy", {24'd0, busy_a}, 32'h40);
        done_a = 8'h40; step(); done_a = 8'h00;
        chk("t6_new_cnt", {16'd0, cnt_of(6)}, 32'd1);
        chk("t6_new_irq", {24'd0, irq_a}, 32'h40);

        // 5: CNT_W=4 instance saturates at 15 after 17 jobs on MVU 1
        for (int j = 0; j < 17; j++) begin
            start_b = 8'h02; step(); start_b = 8'h00;
            done_b  = 8'h02; step(); done_b  = 8'h00;
            if (j == 14) begin
                chk("t5_cnt15", {28'd0, cnt_b[7:4]}, 32'd15);
            end
        end
        chk("t5_sat",   {28'd0, cnt_b[7:4]}, 32'd15);
        chk("t5_other", {28'd0, cnt_b[3:0]}, 32'd0);
        chk("t5_irq",   {24'd0, irq_b}, 32'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
